uart_gen2: RTL and testbench
============================

UART_GEN2 -- requirements
Module: uart_gen2

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, i_clk frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, baud rate at reset.
REQ-003 SHALL have parameter OVERSAMPLE, default 8, ticks per bit; power of 2, >=4.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, entries per RX and TX FIFO; power of 2, >=2.
REQ-005 SHALL use one clock and a synchronous, active-high reset: i_clk  in  1  sole clock; i_rst  in  1  reset.
REQ-006 SHALL have ports rx  in  1  serial in, async; tx  out  1  serial out.
REQ-007 SHALL have Wishbone ports wb_cyc, wb_stb, wb_we  in  1 each; wb_adr  in  24; wb_i_dat  in  16; wb_o_dat  out  16; wb_ack  out  1.
REQ-008 SHALL have irq  out  1  level interrupt.

Function
REQ-009 SHALL drive wb_ack = wb_cyc & wb_stb combinationally, zero wait states; wb_o_dat SHALL be combinational from wb_adr.
REQ-010 SHALL decode registers (higher addresses read 0; writes ignored):
- 0 STATUS: b0 rx_avail, b1 tx_not_full, b2 overrun, b3 framing_err, b4 parity_err, b5 tx_idle (TX FIFO empty and shifter idle).
- 1 RXDATA: read pops.
- 2 TXDATA: write pushes wb_i_dat[7:0].
- 3 DIV: 16-bit i_clk cycles per tick.
- 4 CTRL: b0 par_en, b1 par_odd, b2 two_stop, b3 rx_ie, b4 txe_ie, b5 err_ie.
REQ-011 SHALL reset DIV to CLK_FREQ/(BAUD*OVERSAMPLE), truncated; a written DIV of 0 SHALL act as 1; a DIV write SHALL restart the tick counter.
REQ-012 SHALL generate one single-cycle tick every DIV cycles, shared by RX and TX; TX advances one bit every OVERSAMPLE ticks.
REQ-013 STATUS b2..b4 SHALL be sticky, cleared by a STATUS write with the matching bit =1; a simultaneous set SHALL win over the clear.
REQ-014 RXDATA read with RX FIFO non-empty SHALL return {8'b0,head} and pop it in the acked cycle; a read when empty SHALL return 0 and leave the pointers unchanged.
REQ-015 TXDATA write when the TX FIFO is full SHALL be dropped with no flag set.
REQ-016 FIFOs SHALL use log2(FIFO_DEPTH)+1-bit wrap pointers so all FIFO_DEPTH entries are usable; a simultaneous push and pop SHALL both take effect, including when full or empty.
REQ-017 rx SHALL pass a 2-FF synchronizer before any use.
REQ-018 RX FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
- IDLE to START on synced rx=0 at a tick.
- START re-samples at tick OVERSAMPLE/2; rx=1 returns to IDLE (glitch, no flag), rx=0 goes to DATA.
- DATA samples 8 bits, LSB first, each OVERSAMPLE ticks after the previous sample.
- PARITY is entered only when par_en=1.
- STOP samples one stop bit only (two_stop ignored by RX), then returns to IDLE.
REQ-019 At the STOP sample, rx=0 SHALL set framing_err and discard the byte; a parity mismatch (even: XOR of data and parity = 0; odd: = 1) SHALL set parity_err and discard the byte; otherwise the byte SHALL be pushed, or dropped with overrun set if the RX FIFO is full at that cycle, including when a pop occurs in that same cycle.
REQ-020 TX FSM SHALL have states IDLE, START, DATA, PARITY, STOP1, STOP2.
- Leaves IDLE on the first tick-aligned bit boundary with the TX FIFO non-empty, popping the head.
- PARITY only when par_en=1; STOP2 only when two_stop=1.
- Returns to IDLE, then back-to-back start with no extra idle bit.
REQ-021 CTRL changes SHALL take effect at the next frame start; a frame in flight SHALL keep its settings.
REQ-022 irq SHALL = (rx_ie & rx_avail) | (txe_ie & tx_idle) | (err_ie & (overrun|framing_err|parity_err)), registered, one-cycle latency.

Reset
REQ-023 On i_rst SHALL reset:
- tx=1, irq=0, both FSMs IDLE, FIFOs empty, sticky flags 0, CTRL=0, DIV per REQ-011, synchronizer to 1.
- A frame in progress SHALL be abandoned at once with tx=1 in the next cycle.

Structure
REQ-024 Package uart_gen2_pkg SHALL hold register addresses, STATUS/CTRL bit indices and the RX/TX state enums.
REQ-025 Both FIFOs SHALL be instances of one sub-module uart_gen2_fifo (params WIDTH, DEPTH; ports push, pop, din, dout, full, empty).

Verification (DIV=2, OVERSAMPLE=8: 16 clocks/bit)
REQ-026 Write TXDATA 0xA5, CTRL=0 -> tx carries 0,1,0,1,0,0,1,0,1,1, each 16 cycles wide; tx_idle=1 afterwards.
REQ-027 Drive rx frame 0x3C with CTRL par_en=1, par_odd=1 and parity bit 1 -> STATUS b0=1, RXDATA=0x003C, then STATUS b0=0.
REQ-028 Send FIFO_DEPTH+1=9 rx frames without reading -> 8 bytes stored in order, overrun=1; STATUS write 0x0004 clears it.
REQ-029 Frame with stop bit 0 -> framing_err=1, rx_avail=0; rx low pulse of 3 clocks -> no byte, no flag.
REQ-030 Write 10 TX bytes back to back -> last 2 dropped (tx_not_full=0 at 8), 8 frames sent with no idle gaps; i_rst asserted mid-frame -> tx=1 in the next cycle, FIFOs empty.

Source files
------------

// File: rtl/uart_gen2_pkg.sv
// Shared definitions for the uart_gen2 slice: register map, STATUS/CTRL bit
// positions and the receiver/transmitter state encodings.
package uart_gen2_pkg;

   localparam int WB_ADR_W = 24;
   localparam int WB_DAT_W = 16;

   localparam logic [WB_ADR_W-1:0] ADR_STATUS = 24'd0;
   localparam logic [WB_ADR_W-1:0] ADR_RXDATA = 24'd1;
   localparam logic [WB_ADR_W-1:0] ADR_TXDATA = 24'd2;
   localparam logic [WB_ADR_W-1:0] ADR_DIV    = 24'd3;
   localparam logic [WB_ADR_W-1:0] ADR_CTRL   = 24'd4;

   localparam int ST_RX_AVAIL    = 0;
   localparam int ST_TX_NOT_FULL = 1;
   localparam int ST_OVERRUN     = 2;
   localparam int ST_FRAMING     = 3;
   localparam int ST_PARITY      = 4;
   localparam int ST_TX_IDLE     = 5;

   localparam int CT_PAR_EN   = 0;
   localparam int CT_PAR_ODD  = 1;
   localparam int CT_TWO_STOP = 2;
   localparam int CT_RX_IE    = 3;
   localparam int CT_TXE_IE   = 4;
   localparam int CT_ERR_IE   = 5;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rx_state_t;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP1,
      TX_STOP2
   } tx_state_t;

endpackage

// File: rtl/uart_gen2_if.sv
// Wishbone classic register-bus bundle used by uart_gen2 (zero-wait-state slave).
interface uart_gen2_if;
   import uart_gen2_pkg::*;

   logic                wb_cyc;
   logic                wb_stb;
   logic                wb_we;
   logic [WB_ADR_W-1:0] wb_adr;
   logic [WB_DAT_W-1:0] wb_i_dat;
   logic [WB_DAT_W-1:0] wb_o_dat;
   logic                wb_ack;

   modport master (output wb_cyc, wb_stb, wb_we, wb_adr, wb_i_dat,
                   input  wb_o_dat, wb_ack);
   modport slave  (input  wb_cyc, wb_stb, wb_we, wb_adr, wb_i_dat,
                   output wb_o_dat, wb_ack);
endinterface

// File: rtl/uart_gen2_fifo.sv
// Synchronous FIFO with extra-bit wrap pointers so every entry is usable;
// head is presented combinationally on dout.
module uart_gen2_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             wr_en;
   logic             rd_en;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   // A pop frees the slot a same-cycle push lands in, so a full FIFO still accepts it
   assign wr_en = push & (~full | pop);
   assign rd_en = pop & ~empty;
   assign dout  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
   end
endmodule

// File: rtl/uart_gen2.sv
// UART with Wishbone register interface, RX/TX FIFOs, programmable divider,
// optional parity, one/two stop bits and a registered level interrupt.
module uart_gen2
   import uart_gen2_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int OVERSAMPLE = 8,
   parameter int FIFO_DEPTH = 8
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       rx,
   output logic       tx,
   output logic       irq,
   uart_gen2_if.slave wb
);
   localparam logic [15:0] DIV_RST = 16'(CLK_FREQ / (BAUD * OVERSAMPLE));
   localparam int OSW = $clog2(OVERSAMPLE);
   localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
   localparam logic [OSW-1:0] OS_HALF = OSW'(OVERSAMPLE / 2 - 1);

   logic        acc, wr_status, wr_div, wr_ctrl, wr_tx, rd_rx;
   logic [15:0] div_q, div_eff, tick_cnt;
   logic        tick;
   logic [5:0]  ctrl_q, status;
   logic        ov, fe, pe, set_ov, set_fe, set_pe;
   logic        rx_meta, rx_s;
   logic [7:0]  rxf_dout, txf_dout;
   logic        rxf_full, rxf_empty, txf_full, txf_empty;
   logic        rx_push, tx_push, tx_idle;

   assign acc       = wb.wb_cyc & wb.wb_stb;
   assign wb.wb_ack = acc;
   assign wr_status = acc &  wb.wb_we & (wb.wb_adr == ADR_STATUS);
   assign wr_div    = acc &  wb.wb_we & (wb.wb_adr == ADR_DIV);
   assign wr_ctrl   = acc &  wb.wb_we & (wb.wb_adr == ADR_CTRL);
   assign wr_tx     = acc &  wb.wb_we & (wb.wb_adr == ADR_TXDATA);
   assign rd_rx     = acc & ~wb.wb_we & (wb.wb_adr == ADR_RXDATA) & ~rxf_empty;
   assign tx_push   = wr_tx & ~txf_full;

   always_comb begin
      status                 = '0;
      status[ST_RX_AVAIL]    = ~rxf_empty;
      status[ST_TX_NOT_FULL] = ~txf_full;
      status[ST_OVERRUN]     = ov;
      status[ST_FRAMING]     = fe;
      status[ST_PARITY]      = pe;
      status[ST_TX_IDLE]     = tx_idle;
   end

   always_comb begin
      wb.wb_o_dat = '0;
      case (wb.wb_adr)
         ADR_STATUS: wb.wb_o_dat = {10'd0, status};
         ADR_RXDATA: wb.wb_o_dat = rxf_empty ? 16'd0 : {8'd0, rxf_dout};
         ADR_DIV:    wb.wb_o_dat = div_q;
         ADR_CTRL:   wb.wb_o_dat = {10'd0, ctrl_q};
         default:    wb.wb_o_dat = '0;
      endcase
   end

   // Registers, sticky flags (set beats clear), tick generator and rx synchronizer
   assign div_eff = (div_q == 16'd0) ? 16'd1 : div_q;
   assign tick    = (tick_cnt == div_eff - 16'd1);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         div_q    <= DIV_RST;
         tick_cnt <= '0;
         ctrl_q   <= '0;
         ov       <= 1'b0;
         fe       <= 1'b0;
         pe       <= 1'b0;
         rx_meta  <= 1'b1;
         rx_s     <= 1'b1;
         irq      <= 1'b0;
      end else begin
         if (wr_div) begin
            div_q    <= wb.wb_i_dat;
            tick_cnt <= '0;
         end else begin
            tick_cnt <= tick ? 16'd0 : tick_cnt + 16'd1;
         end
         if (wr_ctrl) ctrl_q <= wb.wb_i_dat[5:0];
         ov      <= set_ov | (ov & ~(wr_status & wb.wb_i_dat[ST_OVERRUN]));
         fe      <= set_fe | (fe & ~(wr_status & wb.wb_i_dat[ST_FRAMING]));
         pe      <= set_pe | (pe & ~(wr_status & wb.wb_i_dat[ST_PARITY]));
         rx_meta <= rx;
         rx_s    <= rx_meta;
         irq     <= (ctrl_q[CT_RX_IE]  & status[ST_RX_AVAIL]) |
                    (ctrl_q[CT_TXE_IE] & status[ST_TX_IDLE])  |
                    (ctrl_q[CT_ERR_IE] & (ov | fe | pe));
      end
   end

   // Receiver
   rx_state_t      rx_state, rx_nxt;
   logic [OSW-1:0] rx_tcnt;
   logic [2:0]     rx_bitn;
   logic [7:0]     rx_sh;
   logic           rx_par, rx_cfg_par_en, rx_cfg_par_odd, rx_smp;

   always_comb begin
      rx_nxt  = rx_state;
      rx_push = 1'b0;
      set_ov  = 1'b0;
      set_fe  = 1'b0;
      set_pe  = 1'b0;
      rx_smp  = tick && (rx_tcnt == ((rx_state == RX_START) ? OS_HALF : OS_LAST));
      case (rx_state)
         RX_IDLE:   if (tick && !rx_s) rx_nxt = RX_START;
         RX_START:  if (rx_smp) rx_nxt = rx_s ? RX_IDLE : RX_DATA;
         RX_DATA:   if (rx_smp && rx_bitn == 3'd7) rx_nxt = rx_cfg_par_en ? RX_PARITY : RX_STOP;
         RX_PARITY: if (rx_smp) rx_nxt = RX_STOP;
         RX_STOP: begin
            if (rx_smp) begin
               rx_nxt = RX_IDLE;
               if (!rx_s)                                                      set_fe  = 1'b1;
               else if (rx_cfg_par_en && ((^rx_sh ^ rx_par) != rx_cfg_par_odd)) set_pe  = 1'b1;
               else if (rxf_full)                                              set_ov  = 1'b1;
               else                                                            rx_push = 1'b1;
            end
         end
         default: rx_nxt = RX_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) rx_state <= RX_IDLE;
      else       rx_state <= rx_nxt;
   end

   // The detecting tick is tick 0 of the frame; settings are frozen once it leaves IDLE
   always_ff @(posedge i_clk) begin
      if (rx_state == RX_IDLE) begin
         rx_tcnt        <= '0;
         rx_bitn        <= '0;
         rx_cfg_par_en  <= ctrl_q[CT_PAR_EN];
         rx_cfg_par_odd <= ctrl_q[CT_PAR_ODD];
      end else if (tick) begin
         rx_tcnt <= rx_smp ? '0 : rx_tcnt + OSW'(1);
      end
      if (rx_smp && rx_state == RX_DATA) begin
         rx_sh   <= {rx_s, rx_sh[7:1]};
         rx_bitn <= rx_bitn + 3'd1;
      end
      if (rx_smp && rx_state == RX_PARITY) rx_par <= rx_s;
   end

   // Transmitter: bit boundaries come from a free-running tick sub-counter
   tx_state_t      tx_state, tx_nxt;
   logic [OSW-1:0] tx_tcnt;
   logic [2:0]     tx_bitn;
   logic [7:0]     tx_sh;
   logic           tx_par, tx_cfg_par_en, tx_cfg_two_stop;
   logic           bit_end, tx_load, tx_shift, tx_done, tx_d;

   assign bit_end = tick && (tx_tcnt == OS_LAST);
   assign tx_idle = txf_empty && (tx_state == TX_IDLE);

   always_comb begin
      tx_nxt   = tx_state;
      tx_load  = 1'b0;
      tx_shift = 1'b0;
      tx_done  = 1'b0;
      tx_d     = 1'b1;
      if (bit_end) begin
         case (tx_state)
            TX_IDLE:   tx_done = 1'b1;
            TX_START:  tx_nxt  = TX_DATA;
            TX_DATA: begin
               tx_shift = 1'b1;
               if (tx_bitn == 3'd7) tx_nxt = tx_cfg_par_en ? TX_PARITY : TX_STOP1;
            end
            TX_PARITY: tx_nxt = TX_STOP1;
            TX_STOP1: begin
               if (tx_cfg_two_stop) tx_nxt  = TX_STOP2;
               else                 tx_done = 1'b1;
            end
            TX_STOP2:  tx_done = 1'b1;
            default:   tx_nxt  = TX_IDLE;
         endcase
         if (tx_done) begin
            tx_load = ~txf_empty;
            tx_nxt  = txf_empty ? TX_IDLE : TX_START;
         end
      end
      case (tx_nxt)
         TX_START:  tx_d = 1'b0;
         TX_DATA:   tx_d = tx_shift ? tx_sh[1] : tx_sh[0];
         TX_PARITY: tx_d = tx_par;
         default:   tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         tx_state <= TX_IDLE;
         tx_tcnt  <= '0;
         tx       <= 1'b1;
      end else begin
         tx_state <= tx_nxt;
         if (tick) tx_tcnt <= tx_tcnt + OSW'(1);
         tx       <= tx_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (tx_load) begin
         tx_sh           <= txf_dout;
         tx_bitn         <= '0;
         tx_par          <= ^txf_dout ^ ctrl_q[CT_PAR_ODD];
         tx_cfg_par_en   <= ctrl_q[CT_PAR_EN];
         tx_cfg_two_stop <= ctrl_q[CT_TWO_STOP];
      end else if (tx_shift) begin
         tx_sh   <= {1'b0, tx_sh[7:1]};
         tx_bitn <= tx_bitn + 3'd1;
      end
   end

   uart_gen2_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .push  (rx_push),
      .pop   (rd_rx),
      .din   (rx_sh),
      .dout  (rxf_dout),
      .full  (rxf_full),
      .empty (rxf_empty)
   );

   uart_gen2_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .push  (tx_push),
      .pop   (tx_load),
      .din   (wb.wb_i_dat[7:0]),
      .dout  (txf_dout),
      .full  (txf_full),
      .empty (txf_empty)
   );
endmodule

// File: tb/tb_uart_gen2.sv
// Directed bench for uart_gen2: register table plus serial TX/RX frame sequences
// at DIV=2, OVERSAMPLE=8 (16 clocks per bit).
module tb_uart_gen2;

   logic i_clk;
   logic i_rst;
   logic rx;
   logic tx;
   logic irq;
   int   checks;
   int   errors;

   uart_gen2_if wb ();

   uart_gen2 dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .rx    (rx),
      .tx    (tx),
      .irq   (irq),
      .wb    (wb)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [23:0] adr;
      bit          we;
      logic [15:0] wdat;
      logic [15:0] exp;
   } vec_t;

   vec_t tbl [16];

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   task automatic wb_write(input logic [23:0] a, input logic [15:0] d, output logic ack);
      @(posedge i_clk); #1;
      wb.wb_cyc = 1'b1; wb.wb_stb = 1'b1; wb.wb_we = 1'b1;
      wb.wb_adr = a;    wb.wb_i_dat = d;
      #2 ack = wb.wb_ack;
      @(posedge i_clk); #1;
      wb.wb_cyc = 1'b0; wb.wb_stb = 1'b0; wb.wb_we = 1'b0;
   endtask

   task automatic wr(input logic [23:0] a, input logic [15:0] d);
      logic ack;
      wb_write(a, d, ack);
   endtask

   task automatic wb_read(input logic [23:0] a, output logic [15:0] d, output logic ack);
      @(posedge i_clk); #1;
      wb.wb_cyc = 1'b1; wb.wb_stb = 1'b1; wb.wb_we = 1'b0; wb.wb_adr = a;
      #2;
      d   = wb.wb_o_dat;
      ack = wb.wb_ack;
      @(posedge i_clk); #1;
      wb.wb_cyc = 1'b0; wb.wb_stb = 1'b0;
   endtask

   task automatic rd_check(input string name, input logic [23:0] a, input logic [15:0] exp);
      logic [15:0] d;
      logic ack;
      wb_read(a, d, ack);
      check(name, d, exp);
   endtask

   task automatic rx_bit(input logic v);
      rx = v;
      repeat (16) @(posedge i_clk);
      #1;
   endtask

   task automatic send_rx(input logic [7:0] b, input bit par_en, input logic par, input logic stop);
      @(posedge i_clk); #1;
      rx_bit(1'b0);
      for (int i = 0; i < 8; i++) rx_bit(b[i]);
      if (par_en) rx_bit(par);
      rx_bit(stop);
      rx_bit(1'b1);
      rx_bit(1'b1);
   endtask

   task automatic wait_tx_low(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(posedge i_clk); #1;
         if (tx == 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got no end of test, required finish before time limit");
      $fatal(1);
   end

   initial begin
      logic [15:0] d;
      logic        ack;
      bit          ok;
      logic [9:0]  seq;
      logic [7:0]  by;

      checks = 0;
      errors = 0;
      i_rst = 1'b1;
      rx    = 1'b1;
      wb.wb_cyc = 1'b0; wb.wb_stb = 1'b0; wb.wb_we = 1'b0;
      wb.wb_adr = '0;   wb.wb_i_dat = '0;

      tbl[0]  = '{24'd0,       1'b0, 16'h0000, 16'h0022};
      tbl[1]  = '{24'd1,       1'b0, 16'h0000, 16'h0000};
      tbl[2]  = '{24'd3,       1'b0, 16'h0000, 16'h0036};
      tbl[3]  = '{24'd4,       1'b0, 16'h0000, 16'h0000};
      tbl[4]  = '{24'd5,       1'b0, 16'h0000, 16'h0000};
      tbl[5]  = '{24'd3,       1'b1, 16'h0000, 16'h0000};
      tbl[6]  = '{24'd3,       1'b0, 16'h0000, 16'h0000};
      tbl[7]  = '{24'd3,       1'b1, 16'h0002, 16'h0000};
      tbl[8]  = '{24'd3,       1'b0, 16'h0000, 16'h0002};
      tbl[9]  = '{24'd4,       1'b1, 16'h003F, 16'h0000};
      tbl[10] = '{24'd4,       1'b0, 16'h0000, 16'h003F};
      tbl[11] = '{24'd4,       1'b1, 16'hFFC0, 16'h0000};
      tbl[12] = '{24'd4,       1'b0, 16'h0000, 16'h0000};
      tbl[13] = '{24'd5,       1'b1, 16'h1234, 16'h0000};
      tbl[14] = '{24'd5,       1'b0, 16'h0000, 16'h0000};
      tbl[15] = '{24'h800000,  1'b0, 16'h0000, 16'h0000};

      cyc(3);
      check("reset tx", 16'(tx), 16'h0001);
      check("reset irq", 16'(irq), 16'h0000);
      i_rst = 1'b0;
      cyc(1);

      for (int i = 0; i < 16; i++) begin
         if (tbl[i].we) begin
            wb_write(tbl[i].adr, tbl[i].wdat, ack);
         end else begin
            wb_read(tbl[i].adr, d, ack);
            check($sformatf("vec%0d adr=%0h data", i, tbl[i].adr), d, tbl[i].exp);
         end
         check($sformatf("vec%0d ack", i), 16'(ack), 16'h0001);
      end

      // txe interrupt follows tx_idle while enabled
      wr(24'd4, 16'h0010);
      cyc(2);
      check("irq txe on", 16'(irq), 16'h0001);
      wr(24'd4, 16'h0000);
      cyc(2);
      check("irq txe off", 16'(irq), 16'h0000);

      // Single TX frame 0xA5, 8N1
      seq = 10'b0101001011;
      wr(24'd2, 16'h00A5);
      wait_tx_low(200, ok);
      check("tx026 start seen", 16'(ok), 16'h0001);
      cyc(8);
      for (int i = 0; i < 10; i++) begin
         if (i > 0) cyc(16);
         check($sformatf("tx026 bit%0d", i), 16'(tx), 16'(seq[9-i]));
      end
      cyc(16);
      rd_check("tx026 status idle", 24'd0, 16'h0022);

      // RX odd parity, good frame
      wr(24'd4, 16'h0003);
      send_rx(8'h3C, 1'b1, 1'b1, 1'b1);
      rd_check("rx027 status avail", 24'd0, 16'h0023);
      rd_check("rx027 rxdata", 24'd1, 16'h003C);
      rd_check("rx027 status empty", 24'd0, 16'h0022);

      // RX odd parity, wrong parity bit, with error interrupt enabled
      wr(24'd4, 16'h0023);
      send_rx(8'h3C, 1'b1, 1'b0, 1'b1);
      rd_check("rxpe status", 24'd0, 16'h0032);
      check("rxpe irq", 16'(irq), 16'h0001);
      wr(24'd0, 16'h0010);
      rd_check("rxpe status cleared", 24'd0, 16'h0022);
      cyc(2);
      check("rxpe irq cleared", 16'(irq), 16'h0000);

      // RX overrun: nine frames into an eight-entry FIFO
      wr(24'd4, 16'h0000);
      for (int k = 0; k < 9; k++) send_rx(8'h10 + 8'(k), 1'b0, 1'b0, 1'b1);
      rd_check("rx028 status overrun", 24'd0, 16'h0027);
      for (int k = 0; k < 8; k++)
         rd_check($sformatf("rx028 byte%0d", k), 24'd1, 16'h0010 + 16'(k));
      rd_check("rx028 status drained", 24'd0, 16'h0026);
      wr(24'd0, 16'h0004);
      rd_check("rx028 overrun cleared", 24'd0, 16'h0022);

      // Framing error, then a short glitch
      send_rx(8'h55, 1'b0, 1'b0, 1'b0);
      rd_check("rx029 framing", 24'd0, 16'h002A);
      rd_check("rx029 rxdata empty", 24'd1, 16'h0000);
      wr(24'd0, 16'h0008);
      rd_check("rx029 framing cleared", 24'd0, 16'h0022);
      @(posedge i_clk); #1;
      rx = 1'b0;
      cyc(3);
      rx = 1'b1;
      cyc(100);
      rd_check("rx029 glitch ignored", 24'd0, 16'h0022);

      // Ten back-to-back TX writes with ticks held off, then release
      wr(24'd3, 16'd1000);
      @(posedge i_clk); #1;
      wb.wb_cyc = 1'b1; wb.wb_stb = 1'b1; wb.wb_we = 1'b1; wb.wb_adr = 24'd2;
      for (int k = 0; k < 10; k++) begin
         wb.wb_i_dat = 16'h00C0 + 16'(k);
         @(posedge i_clk); #1;
      end
      wb.wb_cyc = 1'b0; wb.wb_stb = 1'b0; wb.wb_we = 1'b0;
      rd_check("tx030 status full", 24'd0, 16'h0000);
      wr(24'd3, 16'h0002);
      wait_tx_low(100, ok);
      check("tx030 start seen", 16'(ok), 16'h0001);
      cyc(8);
      for (int f = 0; f < 8; f++) begin
         check($sformatf("tx030 f%0d start", f), 16'(tx), 16'h0000);
         for (int b = 0; b < 8; b++) begin
            cyc(16);
            by[b] = tx;
         end
         cyc(16);
         check($sformatf("tx030 f%0d stop", f), 16'(tx), 16'h0001);
         check($sformatf("tx030 f%0d byte", f), 16'(by), 16'h00C0 + 16'(f));
         cyc(16);
      end
      check("tx030 no ninth frame", 16'(tx), 16'h0001);
      cyc(16);
      rd_check("tx030 status idle", 24'd0, 16'h0022);

      // Reset in the middle of a frame with both FIFOs holding data
      send_rx(8'h77, 1'b0, 1'b0, 1'b1);
      wr(24'd2, 16'h0000);
      wr(24'd2, 16'h0000);
      wr(24'd2, 16'h0000);
      wait_tx_low(100, ok);
      check("rst start seen", 16'(ok), 16'h0001);
      cyc(20);
      check("rst tx mid frame", 16'(tx), 16'h0000);
      i_rst = 1'b1;
      cyc(1);
      check("rst tx next cycle", 16'(tx), 16'h0001);
      i_rst = 1'b0;
      rd_check("rst status", 24'd0, 16'h0022);
      rd_check("rst div", 24'd3, 16'h0036);
      cyc(50);
      check("rst tx stays idle", 16'(tx), 16'h0001);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
